// File: rtl/hgcal_input_quantizer.sv
// hgcal_input_quantizer
//   Front-end stage ahead of the first LUT layer of the HGCAL autoencoder.
//   Accepts signed samples one per cycle on valid/ready. Each sample becomes
//   an OUT_BITS unsigned code. NUM_INPUTS codes are packed into a frame, and
//   the frame is presented as a registered flat vector on valid/ready.
//   Slot k of out_data sits in bits [k*OUT_BITS +: OUT_BITS], with slot 0 at the LSB.
//   Optional feature: define QUANT_ROUND_EN to select round-half-up
//   quantization. The default is truncation (floor).
module hgcal_input_quantizer #(
    parameter int NUM_INPUTS = 48,
    parameter int IN_WIDTH   = 8,
    parameter int OUT_BITS   = 2,
    parameter int SHIFT      = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [IN_WIDTH-1:0]            in_data,
    input  logic                           in_last,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [NUM_INPUTS*OUT_BITS-1:0] out_data,
    output logic                           frame_err,
    output logic [15:0]                    frame_cnt
);

    localparam int FRAME_W = NUM_INPUTS * OUT_BITS;
    localparam int IDX_W   = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam int QW      = IN_WIDTH + 1;
    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NUM_INPUTS - 1);
    localparam logic signed [QW-1:0] CODE_MAX = QW'((1 << OUT_BITS) - 1);

    logic [IDX_W-1:0]     idx;
    logic [FRAME_W-1:0]   acc;
    logic [FRAME_W-1:0]   acc_upd;
    logic                 hold;
    logic                 out_valid_r;
    logic [FRAME_W-1:0]   out_data_r;
    logic                 frame_err_r;
    logic [15:0]          frame_cnt_r;

    logic signed [QW-1:0] ext_data;
    logic signed [QW-1:0] q;
    logic [OUT_BITS-1:0]  code;

    logic accept;
    logic at_last;
    logic close;
    logic early;
    logic can_load;

    // Sign-extend by one bit so the rounding offset can never overflow.
    assign ext_data = {in_data[IN_WIDTH-1], in_data};

`ifdef QUANT_ROUND_EN
    localparam logic signed [QW-1:0] HALF = QW'(1 << (SHIFT - 1));
    assign q = (ext_data + HALF) >>> SHIFT;
`else
    assign q = ext_data >>> SHIFT;
`endif

    // Saturate the scaled sample into the unsigned code range.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        code = '0;
        if (q[QW-1])
            code = '0;
        else if (q > CODE_MAX)
            code = '1;
        else
            code = q[OUT_BITS-1:0];
    end

    // Accumulator image with the current code placed at slot idx.
    always_comb begin
        acc_upd = acc;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            if (accept && idx == IDX_W'(k))
                acc_upd[k*OUT_BITS +: OUT_BITS] = code;
        end
    end

    // in_ready depends only on registered state. It never depends on out_ready.
    assign in_ready = ~hold;
    assign accept   = in_valid & ~hold;
    assign at_last  = (idx == LAST_IDX);
    assign close    = accept & at_last;
    assign early    = accept & in_last & ~at_last;
    assign can_load = ~out_valid_r | out_ready;

    // Frame assembly, output hand-off, hold/backpressure and error pulse.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            idx         <= '0;
            acc         <= '0;
            hold        <= 1'b0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            frame_err_r <= 1'b0;
            frame_cnt_r <= '0;
        end else begin
            frame_err_r <= early | (close & ~in_last);

            if (accept) begin
                if (early) begin
                    idx <= '0;
                    acc <= '0;
                end else begin
                    acc <= acc_upd;
                    idx <= at_last ? '0 : idx + 1'b1;
                end
            end

            if (close) begin
                if (can_load) begin
                    out_data_r  <= acc_upd;
                    out_valid_r <= 1'b1;
                    frame_cnt_r <= frame_cnt_r + 16'd1;
                end else begin
                    hold <= 1'b1;
                end
            end else if (hold) begin
                // A held frame can only exist while out_valid is high.
                if (out_ready) begin
                    out_data_r  <= acc;
                    hold        <= 1'b0;
                    frame_cnt_r <= frame_cnt_r + 16'd1;
                end
            end else if (out_valid_r && out_ready) begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign frame_err = frame_err_r;
    assign frame_cnt = frame_cnt_r;

endmodule

// File: tb/tb_hgcal_input_quantizer.sv
// tb_hgcal_input_quantizer
//   Directed bench for hgcal_input_quantizer with NUM_INPUTS=4, IN_WIDTH=8,
//   OUT_BITS=2 and SHIFT=4. Expected values are hand-computed codes. Inputs
//   change 1 time unit after the rising edge, and outputs are sampled at the same point.
module tb_hgcal_input_quantizer;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       frame_err;
    logic [15:0] frame_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    hgcal_input_quantizer #(
        .NUM_INPUTS(4),
        .IN_WIDTH  (8),
        .OUT_BITS  (2),
        .SHIFT     (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .frame_err(frame_err),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_last   = 1'b0;
        out_ready = 1'b1;
        do_reset();

        // Reset state.
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data",  out_data,  0);
        check("rst_frame_err", frame_err, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_in_ready",  in_ready,  1);

        // Test 1: codes 2,3,0,1 pack to 8'b01_00_11_10.
        send(8'h25, 0); send(8'h7F, 0); send(8'hFB, 0); send(8'h10, 1);
        check("t1_out_valid", out_valid, 1);
        check("t1_out_data",  out_data,  8'b01_00_11_10);
        check("t1_frame_cnt", frame_cnt, 1);
        check("t1_frame_err", frame_err, 0);
        step();
        check("t1_drain_valid", out_valid, 0);

        // Test 2: 0x18 gives 1 when truncating and 2 when rounding. 0x7F saturates to 3. 0xF8 and 0x00 give 0.
        send(8'h18, 0); send(8'h7F, 0); send(8'hF8, 0); send(8'h00, 1);
`ifdef QUANT_ROUND_EN
        check("t2_slot0", out_data[1:0], 2);
`else
        check("t2_slot0", out_data[1:0], 1);
`endif
        check("t2_slot1_sat", out_data[3:2], 3);
        check("t2_slot2_neg", out_data[5:4], 0);
        check("t2_frame_cnt", frame_cnt, 2);
        step();

        // Test 3: backpressure. Frame A (1,2,3,0) is 0x39. Frame B (3,3,0,1) is 0x4F.
        out_ready = 1'b0;
        send(8'h10, 0); send(8'h20, 0); send(8'h30, 0); send(8'h00, 1);
        check("t3_a_valid", out_valid, 1);
        check("t3_a_data",  out_data,  8'h39);
        check("t3_a_ready", in_ready,  1);
        send(8'h30, 0); send(8'h30, 0); send(8'h00, 0); send(8'h10, 1);
        check("t3_b_in_ready", in_ready,  0);
        check("t3_b_hold_data", out_data, 8'h39);
        check("t3_b_cnt", frame_cnt, 3);
        step();
        check("t3_stable_data", out_data, 8'h39);
        check("t3_stable_ready", in_ready, 0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("t3_rel_data",  out_data,  8'h4F);
        check("t3_rel_valid", out_valid, 1);
        check("t3_rel_ready", in_ready,  1);
        check("t3_rel_cnt",   frame_cnt, 4);
        out_ready = 1'b1;
        step();
        check("t3_drain_valid", out_valid, 0);

        // Test 3b: the frame closes while out_ready is high. The new frame replaces the old one with no hold.
        out_ready = 1'b0;
        send(8'h10, 0); send(8'h20, 0); send(8'h30, 0); send(8'h00, 1);
        send(8'h30, 0); send(8'h30, 0); send(8'h00, 0);
        out_ready = 1'b1;
        send(8'h10, 1);
        check("t3b_data",  out_data,  8'h4F);
        check("t3b_valid", out_valid, 1);
        check("t3b_ready", in_ready,  1);
        check("t3b_cnt",   frame_cnt, 6);
        step();

        // Test 4: an early last on the 2nd sample. Then a good frame (2,1,3,0) gives 0x36.
        send(8'h10, 0); send(8'h20, 1);
        check("t4_err_pulse", frame_err, 1);
        check("t4_no_valid",  out_valid, 0);
        check("t4_cnt_same",  frame_cnt, 6);
        step();
        check("t4_err_clear", frame_err, 0);
        send(8'h20, 0); send(8'h10, 0); send(8'h30, 0); send(8'h00, 1);
        check("t4_data",  out_data,  8'h36);
        check("t4_valid", out_valid, 1);
        check("t4_cnt",   frame_cnt, 7);
        check("t4_noerr", frame_err, 0);
        step();

        // Test 5: a missing last. Frame (0,1,2,3) gives 0xE4, and frame_err pulses on the same edge.
        send(8'h00, 0); send(8'h10, 0); send(8'h20, 0); send(8'h30, 0);
        check("t5_valid", out_valid, 1);
        check("t5_data",  out_data,  8'hE4);
        check("t5_err",   frame_err, 1);
        check("t5_cnt",   frame_cnt, 8);
        step();
        check("t5_err_clear", frame_err, 0);

        // Test 6a: reset while a frame is held.
        out_ready = 1'b0;
        send(8'h10, 0); send(8'h10, 0); send(8'h10, 0); send(8'h10, 1);
        send(8'h20, 0); send(8'h20, 0); send(8'h20, 0); send(8'h20, 1);
        check("t6_held", in_ready, 0);
        do_reset();
        check("t6a_valid", out_valid, 0);
        check("t6a_data",  out_data,  0);
        check("t6a_cnt",   frame_cnt, 0);
        check("t6a_ready", in_ready,  1);

        // Test 6b: reset after two samples. The next frame must start at slot 0.
        out_ready = 1'b1;
        send(8'h20, 0); send(8'h20, 0);
        do_reset();
        check("t6b_err",   frame_err, 0);
        check("t6b_valid", out_valid, 0);
        send(8'h30, 0); send(8'h00, 0); send(8'h00, 0); send(8'h00, 1);
        check("t6b_data",  out_data,  8'h03);
        check("t6b_valid2", out_valid, 1);
        check("t6b_cnt",   frame_cnt, 1);
        check("t6b_noerr", frame_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
